// File: rtl/cpu_ctrl_fsm_if.sv
// Controller-side bus: imem/alu inputs in, pc/regfile/alu control and status out.
// master = controller, slave = datapath/environment.
interface cpu_ctrl_fsm_if #(
    parameter int PC_W   = 16,
    parameter int REG_AW = 3
);
    logic              start;
    logic [15:0]       instr;
    logic              alu_zero;
    logic              alu_carry;
    logic [PC_W-1:0]   pc;
    logic [2:0]        alu_ctrl;
    logic [REG_AW-1:0] rf_rega;
    logic [REG_AW-1:0] rf_regb;
    logic [REG_AW-1:0] rf_wreg;
    logic              rf_we;
    logic              flag_z;
    logic              flag_c;
    logic              busy;
    logic              halted;
    logic              illegal;

    modport master (
        input  start, instr, alu_zero, alu_carry,
        output pc, alu_ctrl, rf_rega, rf_regb, rf_wreg, rf_we,
               flag_z, flag_c, busy, halted, illegal
    );

    modport slave (
        output start, instr, alu_zero, alu_carry,
        input  pc, alu_ctrl, rf_rega, rf_regb, rf_wreg, rf_we,
               flag_z, flag_c, busy, halted, illegal
    );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Four-cycle FETCH/DECODE/EXEC/WB sequencer for the 16-bit CPU with flags,
// conditional branches, HALT and a sticky illegal-opcode indicator.
module cpu_ctrl_fsm #(
    parameter int              PC_W     = 16,
    parameter int              REG_AW   = 3,
    parameter int              OPC_W    = 16 - 3 * REG_AW,
    parameter logic [PC_W-1:0] MAX_PC   = {PC_W{1'b1}},
    parameter logic [OPC_W-1:0] HALT_OPC = {OPC_W{1'b1}}
) (
    input logic            clk,
    input logic            rst_n,
    cpu_ctrl_fsm_if.master bus
);
    localparam int OFF_W = 3 * REG_AW;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;

    state_t            state, state_nxt;
    logic [15:0]       ir;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   pc_calc;
    logic [OPC_W-1:0]  opc;
    logic              is_alu, is_bz, is_bc, is_halt, is_ill;
    logic              take, over;
    logic [2:0]        alu_ctrl_q;
    logic              flag_z_q, flag_c_q, illegal_q;

    assign opc     = ir[15 -: OPC_W];
    assign is_alu  = opc < OPC_W'(5);
    assign is_bz   = opc == OPC_W'(5);
    assign is_bc   = opc == OPC_W'(6);
    assign is_halt = opc == HALT_OPC;
    assign is_ill  = !(is_alu || is_bz || is_bc || is_halt);

    // Branch offset is the whole operand field, sign-extended; wrap is legal.
    always_comb begin
        take    = (is_bz && flag_z_q) || (is_bc && flag_c_q);
        pc_calc = take ? pc_q + {{(PC_W-OFF_W){ir[OFF_W-1]}}, ir[OFF_W-1:0]}
                       : pc_q + PC_W'(1);
        over    = pc_calc > MAX_PC;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = FETCH;
            FETCH:   state_nxt = DECODE;
            DECODE:  state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = (is_halt || over) ? HALT : FETCH;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= '0;
            ir         <= '0;
            alu_ctrl_q <= '0;
            flag_z_q   <= 1'b0;
            flag_c_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            case (state)
                IDLE:   if (bus.start) pc_q <= '0;
                FETCH:  ir <= bus.instr;
                DECODE: begin
                    alu_ctrl_q <= is_alu ? opc[2:0] : 3'd0;
                    if (is_ill) illegal_q <= 1'b1;
                end
                EXEC: if (is_alu) begin
                    flag_z_q <= bus.alu_zero;
                    flag_c_q <= bus.alu_carry;
                end
                WB: if (!is_halt) pc_q <= over ? MAX_PC : pc_calc;
                default: ;
            endcase
        end
    end

    // Register addresses come straight from ir, so they hold from DECODE through WB.
    always_comb begin
        bus.pc       = pc_q;
        bus.alu_ctrl = alu_ctrl_q;
        bus.rf_wreg  = ir[3*REG_AW-1 -: REG_AW];
        bus.rf_rega  = ir[2*REG_AW-1 -: REG_AW];
        bus.rf_regb  = ir[REG_AW-1:0];
        bus.rf_we    = (state == WB) && is_alu;
        bus.flag_z   = flag_z_q;
        bus.flag_c   = flag_c_q;
        bus.busy     = (state != IDLE) && (state != HALT);
        bus.halted   = state == HALT;
        bus.illegal  = illegal_q;
    end
endmodule
